tcm_boot_ctrl: RTL

Boot sequencer for the RISC-V TCM SoC. It accepts a program as a valid/ready word stream and writes it into instruction TCM through the instruction write port (we/addr/data). It then pulses the core reset and runs the core until the fetch PC reaches a configured end address or a cycle budget expires, and reports the outcome. It sits between a host/loader stream and riscv_tcm_top's instruction-write and rst_cpu inputs.

---
 rtl/tcm_boot_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tcm_boot_ctrl.sv
// Boot sequencer: streams a program image into instruction TCM, pulses the
// core reset, then runs the core until the fetch PC hits the configured end
// address (followed by a drain period) or the run-cycle budget expires.
module tcm_boot_ctrl #(
  parameter int unsigned RST_CYCLES   = 1,
  parameter int unsigned DRAIN_CYCLES = 50,
  parameter int unsigned MAX_CYCLES   = 40000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] word_cnt_i,
  input  logic [31:0]      end_pc_i,
  input  logic             wr_valid_i,
  input  logic [31:0]      wr_data_i,
  output logic             wr_ready_o,
  output logic [3:0]       inst_we_o,
  output logic [31:0]      inst_addr_o,
  output logic [31:0]      inst_data_o,
  output logic             rst_cpu_o,
  input  logic [31:0]      pc_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [31:0]      run_cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CPU_RST,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [31:0]      r_next_addr;
  logic [CNT_W-1:0] r_remaining;
  logic [31:0]      r_end_pc;
  logic [3:0]       r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic             r_done;
  logic             r_timeout;
  logic [31:0]      r_run_cycles;
  logic [31:0]      r_timer;

  logic             w_idle_like;
  logic             w_start_ok;
  logic             w_ready;
  logic             w_hs;
  logic             w_last;
  logic             w_rst_done;
  logic             w_match;
  logic             w_budget;
  logic             w_drain_done;

  // Control decodes, all from registered state (no path from wr_valid_i to ready)
  always_comb begin
    w_idle_like  = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TIMEOUT);
    w_start_ok   = start_i && w_idle_like;
    w_ready      = (r_state == S_LOAD) && (r_remaining != '0);
    w_hs         = wr_valid_i && w_ready;
    w_last       = w_hs && (r_remaining == CNT_W'(1));
    // The reset hold count starts only once the final write has left the port.
    w_rst_done   = (r_state == S_CPU_RST) && (r_we == '0) &&
                   ((r_timer + 32'd1) >= 32'(RST_CYCLES));
    w_match      = (pc_i == r_end_pc);
    w_budget     = ((r_run_cycles + 32'd1) == 32'(MAX_CYCLES));
    w_drain_done = ((r_timer + 32'd1) >= 32'(DRAIN_CYCLES));
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start_i) begin
          w_state_nxt = (word_cnt_i == '0) ? S_CPU_RST : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_last) begin
          w_state_nxt = S_CPU_RST;
        end
      end
      S_CPU_RST: begin
        if (w_rst_done) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_match) begin
          w_state_nxt = S_DRAIN;
        end else if (w_budget) begin
          w_state_nxt = S_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort_i) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Config capture and TCM write port: one registered write per handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_next_addr <= '0;
      r_remaining <= '0;
      r_end_pc    <= '0;
      r_we        <= '0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_we <= '0;
      if (!abort_i) begin
        if (w_start_ok) begin
          r_next_addr <= {base_addr_i[31:2], 2'b00};
          r_remaining <= word_cnt_i;
          r_end_pc    <= end_pc_i;
        end
        if (w_hs) begin
          r_we        <= '1;
          r_addr      <= r_next_addr;
          r_data      <= wr_data_i;
          r_next_addr <= r_next_addr + 32'd4;
          r_remaining <= r_remaining - CNT_W'(1);
        end
      end
    end
  end

  // Run statistics and sticky outcome flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_run_cycles <= '0;
    end else if (abort_i) begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_done       <= 1'b0;
        r_timeout    <= 1'b0;
        r_run_cycles <= '0;
      end
      if (r_state == S_RUN) begin
        r_run_cycles <= r_run_cycles + 32'd1;
        if (!w_match && w_budget) begin
          r_timeout <= 1'b1;
        end
      end
      if ((r_state == S_DRAIN) && w_drain_done) begin
        r_done <= 1'b1;
      end
    end
  end

  // Shared cycle timer for CPU_RST hold and DRAIN; cleared on every state change
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timer <= '0;
    end else if (w_state_nxt != r_state) begin
      r_timer <= '0;
    end else if (((r_state == S_CPU_RST) && (r_we == '0)) || (r_state == S_DRAIN)) begin
      r_timer <= r_timer + 32'd1;
    end
  end

  assign wr_ready_o   = w_ready;
  assign inst_we_o    = r_we;
  assign inst_addr_o  = r_addr;
  assign inst_data_o  = r_data;
  assign rst_cpu_o    = !((r_state == S_RUN) || (r_state == S_DRAIN));
  assign busy_o       = !w_idle_like;
  assign done_o       = r_done;
  assign timeout_o    = r_timeout;
  assign run_cycles_o = r_run_cycles;

endmodule
